// File: rtl/wb_src_sel_pipe.sv
// Writeback source-select stage: picks one of NUM_SRC result buses, applies load
// extraction and registers rd/we/data. Define WB_MISALIGN_MERGE_EN for two-beat merge.
module wb_src_sel_pipe #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [SEL_W-1:0]            src_sel,
  input  logic                        is_load,
  input  logic [1:0]                  ld_size,
  input  logic                        ld_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0] ld_off,
  input  logic [4:0]                  rd_addr,
  input  logic                        rd_we,
  output logic                        hi_req,
  output logic                        wb_valid,
  output logic [DATA_W-1:0]           wb_data,
  output logic [4:0]                  wb_rd,
  output logic                        wb_we,
  output logic                        wb_misalign
);
  localparam int NB = DATA_W / 8;

  // Handshake: a beat is consumed on a rising edge with in_valid=1, stall=0,
  // flush=0; flush overrides stall, stall overrides in_valid.

  function automatic logic [DATA_W-1:0] pick_src(
    input logic [NUM_SRC*DATA_W-1:0] srcs,
    input logic [SEL_W-1:0]          sel
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(sel) == k) r = srcs[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // A dword request on a 32-bit datapath degrades to a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    return (DATA_W == 32 && sz == 2'd3) ? 2'd2 : sz;
  endfunction

  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] x,
    input logic [1:0]        sz,
    input logic              uns
  );
    logic [DATA_W-1:0] r;
    int                nbits;
    logic              fill;
    case (sz)
      2'd0: begin nbits = 8;  fill = x[7];  end
      2'd1: begin nbits = 16; fill = x[15]; end
      2'd2: begin nbits = 32; fill = x[31]; end
      default: begin nbits = DATA_W; fill = x[DATA_W-1]; end
    endcase
    fill = fill & ~uns;
    r = x;
    for (int b = 0; b < DATA_W; b++) begin
      if (b >= nbits) r[b] = fill;
    end
    return r;
  endfunction

  logic [DATA_W-1:0] sel_data;
  logic [1:0]        size_eff;
  logic              ld_misal;
  logic [DATA_W-1:0] result;

  always_comb begin
    sel_data = pick_src(src_data, src_sel);
    size_eff = eff_size(ld_size);
    ld_misal = is_load && ((int'(ld_off) + (1 << size_eff)) > NB);
    result   = is_load ? extend(sel_data >> {ld_off, 3'b000}, size_eff, ld_unsigned)
                       : sel_data;
  end

`ifdef WB_MISALIGN_MERGE_EN
  localparam int OFF_W = $clog2(NB);

  typedef enum logic {IDLE = 1'b0, HI_WAIT = 1'b1} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] lo_q;
  logic [4:0]        rd_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OFF_W-1:0]  off_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] hi_data;
  logic [DATA_W-1:0] merged;

  // The high beat always comes from the source latched with the low beat.
  always_comb begin
    hi_data = pick_src(src_data, sel_q);
    merged  = extend(DATA_W'({hi_data, lo_q} >> {off_q, 3'b000}), size_q, uns_q);
  end

  assign hi_req = (state_q == HI_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
      state_q     <= IDLE;
      lo_q        <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      sel_q       <= '0;
    end else if (flush) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
      state_q     <= IDLE;
    end else if (!stall) begin
      wb_misalign <= 1'b0;
      if (!in_valid) begin
        wb_valid <= 1'b0;
        wb_we    <= 1'b0;
      end else if (state_q == HI_WAIT) begin
        wb_valid <= 1'b1;
        wb_data  <= merged;
        wb_rd    <= rd_q;
        wb_we    <= we_q;
        state_q  <= IDLE;
      end else if (ld_misal) begin
        wb_valid <= 1'b0;
        wb_we    <= 1'b0;
        lo_q     <= sel_data;
        rd_q     <= rd_addr;
        we_q     <= rd_we;
        size_q   <= size_eff;
        uns_q    <= ld_unsigned;
        off_q    <= ld_off;
        sel_q    <= src_sel;
        state_q  <= HI_WAIT;
      end else begin
        wb_valid <= 1'b1;
        wb_data  <= result;
        wb_rd    <= rd_addr;
        wb_we    <= rd_we;
      end
    end
  end
`else
  assign hi_req = 1'b0;

  // Without merge hardware a word-crossing load becomes a one-cycle exception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (flush) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (!stall) begin
      if (!in_valid) begin
        wb_valid    <= 1'b0;
        wb_we       <= 1'b0;
        wb_misalign <= 1'b0;
      end else begin
        wb_valid    <= 1'b1;
        wb_rd       <= rd_addr;
        wb_we       <= rd_we & ~ld_misal;
        wb_misalign <= ld_misal;
        wb_data     <= ld_misal ? '0 : result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_src_sel_pipe.sv
// Self-checking bench for wb_src_sel_pipe; covers both builds of WB_MISALIGN_MERGE_EN.
module tb_wb_src_sel_pipe;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 5;  // leaves sel codes 5..7 out of range
  localparam int SEL_W   = $clog2(NUM_SRC);
  localparam int NB      = DATA_W / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int EW      = 1 + DATA_W + 5 + 1 + 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid, stall, flush;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          src_sel;
  logic                      is_load;
  logic [1:0]                ld_size;
  logic                      ld_unsigned;
  logic [OFF_W-1:0]          ld_off;
  logic [4:0]                rd_addr;
  logic                      rd_we;
  logic                      hi_req, wb_valid, wb_we, wb_misalign;
  logic [DATA_W-1:0]         wb_data;
  logic [4:0]                wb_rd;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got, exp;
  int n_pass  = 0;
  int n_total = 0;

  // clock
  always #5 clk = ~clk;

  wb_src_sel_pipe #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .src_data(src_data), .src_sel(src_sel), .is_load(is_load), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_off(ld_off), .rd_addr(rd_addr), .rd_we(rd_we),
    .hi_req(hi_req), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_misalign(wb_misalign)
  );

  function automatic logic [EW-1:0] pk(input logic v, input logic [DATA_W-1:0] d,
                                       input logic [4:0] rd, input logic we, input logic mis);
    return {v, d, rd, we, mis};
  endfunction

  // Byte-wise reference for aligned loads.
  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] w, input logic ld,
                                              input int sz, input int off, input logic uns);
    logic [DATA_W-1:0] r;
    int nbytes;
    logic neg;
    if (!ld) return w;
    nbytes = (sz >= 2) ? 4 : (1 << sz);
    neg = !uns && w[8*(off+nbytes)-1];
    for (int i = 0; i < NB; i++) begin
      if (i < nbytes) r[8*i +: 8] = w[8*(off+i) +: 8];
      else r[8*i +: 8] = {8{neg}};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                       input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [OFF_W-1:0] off, input logic [4:0] rd, input logic we);
    in_valid = v; stall = st; flush = fl; src_sel = sel; is_load = ld; ld_size = sz;
    ld_unsigned = uns; ld_off = off; rd_addr = rd; rd_we = we;
    for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = $urandom();
    if (int'(sel) < NUM_SRC) src_data[int'(sel)*DATA_W +: DATA_W] = d;
  endtask

  // Second beat: junk on every control pin, high word planted at the held source.
  task automatic drive_beat(input logic st, input logic fl, input int hold_sel,
                            input logic [DATA_W-1:0] h);
    drive(1'b1, st, fl, '0, $urandom(), 1'b0, 2'd0, 1'b1, '0, 5'd31, 1'b0);
    src_data[hold_sel*DATA_W +: DATA_W] = h;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 5'd0, 1'b0);
    tick();
    tick();
    n_total++;
    if ({hi_req, wb_valid, wb_data, wb_rd, wb_we, wb_misalign} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {hi_req, wb_valid, wb_data, wb_rd, wb_we, wb_misalign});
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++;
    if ({hi_req, wb_valid, wb_we, wb_misalign} !== 4'b0)
      $display("FAIL reset_release got=%b exp=0", {hi_req, wb_valid, wb_we, wb_misalign});
    else n_pass++;
  endtask

  task automatic test_nonload();
    drive(1'b1, 1'b0, 1'b0, 3'd7, 32'h1111_2222, 1'b0, 2'd0, 1'b0, '0, 5'd9, 1'b1);
    exp_q.push_back(pk(1'b1, 32'h0, 5'd9, 1'b1, 1'b0));
    tick();
    exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
    n_total++;
    if (got !== exp) $display("FAIL nonload_sel7 got=%h exp=%h", got, exp); else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 3'd2, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0, '0, 5'd5, 1'b1);
    exp_q.push_back(pk(1'b1, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0));
    tick();
    exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
    n_total++;
    if (got !== exp) $display("FAIL nonload_sel2 got=%h exp=%h", got, exp); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 3'd1, 32'h5555_5555, 1'b0, 2'd0, 1'b0, '0, 5'd7, 1'b1);
    tick();
    n_total++;
    if ({wb_valid, wb_we, wb_data} !== {2'b00, 32'hDEAD_BEEF})
      $display("FAIL idle_hold got=%h exp=%h", {wb_valid, wb_we, wb_data}, {2'b00, 32'hDEAD_BEEF});
    else n_pass++;
  endtask

  task automatic test_load_extract();
    logic [DATA_W-1:0] t_src [6] = '{32'h8012_3456, 32'h8012_3456, 32'h9ABC_0000,
                                     32'h9ABC_0000, 32'h1234_5678, 32'h1234_F678};
    logic [1:0]        t_sz  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd1};
    logic              t_uns [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [OFF_W-1:0]  t_off [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [DATA_W-1:0] t_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9ABC,
                                     32'h0000_9ABC, 32'h1234_5678, 32'hFFFF_F678};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd1, t_src[i], 1'b1, t_sz[i], t_uns[i], t_off[i], 5'(10 + i), 1'b1);
      exp_q.push_back(pk(1'b1, t_exp[i], 5'(10 + i), 1'b1, 1'b0));
      tick();
      exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
      n_total++;
      if (got !== exp) $display("FAIL load_extract_%0d got=%h exp=%h", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'hA5A5_0001, 1'b0, 2'd0, 1'b0, '0, 5'd3, 1'b1);
    exp_q.push_back(pk(1'b1, 32'hA5A5_0001, 5'd3, 1'b1, 1'b0));
    tick();
    exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
    n_total++;
    if (got !== exp) $display("FAIL stall_setup got=%h exp=%h", got, exp); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h0BAD_0000 + i, 1'b0, 2'd0, 1'b0, '0, 5'd20, 1'b0);
      exp_q.push_back(pk(1'b1, 32'hA5A5_0001, 5'd3, 1'b1, 1'b0));
      tick();
      exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
      n_total++;
      if (got !== exp) $display("FAIL stall_hold_%0d got=%h exp=%h", i, got, exp); else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b1, 3'd1, 32'h0BAD_1111, 1'b0, 2'd0, 1'b0, '0, 5'd21, 1'b1);
    tick();
    n_total++;
    if ({wb_valid, wb_we, wb_misalign} !== 3'b000)
      $display("FAIL flush_and_stall got=%b exp=000", {wb_valid, wb_we, wb_misalign});
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_4444, 1'b0, 2'd0, 1'b0, '0, 5'd22, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_5555, 1'b0, 2'd0, 1'b0, '0, 5'd23, 1'b1);
    tick();
    n_total++;
    if ({wb_valid, wb_we, wb_misalign} !== 3'b000)
      $display("FAIL flush_kill got=%b exp=000", {wb_valid, wb_we, wb_misalign});
    else n_pass++;
  endtask

`ifdef WB_MISALIGN_MERGE_EN
  task automatic test_merge();
    logic [DATA_W-1:0] t_h   [2] = '{32'h8877_6655, 32'h8877_66F5};
    logic [1:0]        t_sz  [2] = '{2'd2, 2'd1};
    logic [OFF_W-1:0]  t_off [2] = '{2'd2, 2'd3};
    logic [DATA_W-1:0] t_exp [2] = '{32'h6655_4433, 32'hFFFF_F544};
    int                t_sel [2] = '{1, 3};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, SEL_W'(t_sel[i]), 32'h4433_2211, 1'b1, t_sz[i], 1'b0, t_off[i],
            5'(7 + i), 1'b1);
      tick();
      n_total++;
      if ({hi_req, wb_valid, wb_we} !== 3'b100)
        $display("FAIL merge_lo_%0d got=%b exp=100", i, {hi_req, wb_valid, wb_we});
      else n_pass++;
      drive_beat(1'b0, 1'b0, t_sel[i], t_h[i]);
      exp_q.push_back(pk(1'b1, t_exp[i], 5'(7 + i), 1'b1, 1'b0));
      tick();
      exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
      n_total++;
      if (got !== exp) $display("FAIL merge_result_%0d got=%h exp=%h", i, got, exp); else n_pass++;
      n_total++;
      if (hi_req !== 1'b0) $display("FAIL merge_hi_req_%0d got=%b exp=0", i, hi_req); else n_pass++;
    end
  endtask

  task automatic test_hi_wait_stall();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h1357_2468, 1'b0, 2'd0, 1'b0, '0, 5'd2, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd1, 32'h4433_2211, 1'b1, 2'd2, 1'b0, 2'd2, 5'd4, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, 1'b0, 1, 32'h8877_6655);
      tick();
      n_total++;
      if ({hi_req, wb_valid, wb_we, wb_data} !== {3'b100, 32'h1357_2468})
        $display("FAIL hi_wait_stall_%0d got=%h exp=%h", i, {hi_req, wb_valid, wb_we, wb_data},
                 {3'b100, 32'h1357_2468});
      else n_pass++;
    end
    drive_beat(1'b0, 1'b0, 1, 32'h8877_6655);
    exp_q.push_back(pk(1'b1, 32'h6655_4433, 5'd4, 1'b1, 1'b0));
    tick();
    exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
    n_total++;
    if (got !== exp) $display("FAIL stall_then_beat got=%h exp=%h", got, exp); else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 3'd1, 32'h4433_2211, 1'b1, 2'd2, 1'b0, 2'd1, 5'd4, 1'b1);
    tick();
    drive_beat(1'b0, 1'b1, 1, 32'h8877_6655);
    tick();
    n_total++;
    if ({hi_req, wb_valid, wb_we} !== 3'b000)
      $display("FAIL hi_wait_flush got=%b exp=000", {hi_req, wb_valid, wb_we});
    else n_pass++;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 5'd0, 1'b0);
    tick();
    n_total++;
    if ({hi_req, wb_valid} !== 2'b00)
      $display("FAIL after_flush got=%b exp=00", {hi_req, wb_valid});
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 3'd2, 32'h4433_2211, 1'b1, 2'd1, 1'b1, 2'd3, 5'd4, 1'b1);
    tick();
    drive_beat(1'b1, 1'b1, 2, 32'h8877_6655);
    tick();
    n_total++;
    if ({hi_req, wb_valid, wb_we} !== 3'b000)
      $display("FAIL hi_wait_flush_stall got=%b exp=000", {hi_req, wb_valid, wb_we});
    else n_pass++;
  endtask
`else
  task automatic test_misalign();
    logic [1:0]       t_sz  [2] = '{2'd2, 2'd1};
    logic [OFF_W-1:0] t_off [2] = '{2'd1, 2'd3};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd1, 32'h4433_2211, 1'b1, t_sz[i], 1'b0, t_off[i], 5'(6 + i), 1'b1);
      exp_q.push_back(pk(1'b1, 32'h0, 5'(6 + i), 1'b0, 1'b1));
      tick();
      exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
      n_total++;
      if (got !== exp) $display("FAIL misalign_%0d got=%h exp=%h", i, got, exp); else n_pass++;
      n_total++;
      if (hi_req !== 1'b0) $display("FAIL misalign_hi_req_%0d got=%b exp=0", i, hi_req); else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 5'd0, 1'b0);
    tick();
    n_total++;
    if ({wb_valid, wb_we, wb_misalign} !== 3'b000)
      $display("FAIL misalign_one_cycle got=%b exp=000", {wb_valid, wb_we, wb_misalign});
    else n_pass++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] d;
    logic              ld, uns, we;
    int                sz, nbytes, off;
    logic [4:0]        rd;
    for (int i = 0; i < 40; i++) begin
      sel = SEL_W'($urandom_range(0, 7));
      d = $urandom();
      ld = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      sz = $urandom_range(0, 3);
      nbytes = (sz >= 2) ? 4 : (1 << sz);
      off = $urandom_range(0, NB - nbytes);
      drive(1'b1, 1'b0, 1'b0, sel, d, ld, 2'(sz), uns, OFF_W'(off), rd, we);
      exp_q.push_back(pk(1'b1, (int'(sel) < NUM_SRC) ? model(d, ld, sz, off, uns) : '0, rd, we, 1'b0));
      tick();
      exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
      n_total++;
      if (got !== exp) $display("FAIL back_to_back_%0d got=%h exp=%h", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
`ifdef WB_MISALIGN_MERGE_EN
    drive(1'b1, 1'b0, 1'b0, 3'd1, 32'h4433_2211, 1'b1, 2'd2, 1'b0, 2'd2, 5'd4, 1'b1);
`else
    drive(1'b1, 1'b0, 1'b0, 3'd1, 32'h4433_2211, 1'b0, 2'd0, 1'b0, '0, 5'd4, 1'b1);
`endif
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({hi_req, wb_valid, wb_data, wb_rd, wb_we, wb_misalign} !== '0)
      $display("FAIL async_reset got=%h exp=0", {hi_req, wb_valid, wb_data, wb_rd, wb_we, wb_misalign});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd3, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b0, '0, 5'd17, 1'b1);
    exp_q.push_back(pk(1'b1, 32'hCAFE_F00D, 5'd17, 1'b1, 1'b0));
    tick();
    exp = exp_q.pop_front(); got = {wb_valid, wb_data, wb_rd, wb_we, wb_misalign};
    n_total++;
    if (got !== exp) $display("FAIL post_reset_idle got=%h exp=%h", got, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_load_extract();
    test_stall_flush();
`ifdef WB_MISALIGN_MERGE_EN
    test_merge();
    test_hi_wait_stall();
`else
    test_misalign();
`endif
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
